// File: rtl/fifo_rd_unpack.sv
// Drains wide words from a show-ahead FIFO and emits each one as RATIO narrow chunks on a valid/ready stream.
// Optional macro FIFO_RD_UNPACK_MSB_FIRST_EN selects MSB-first chunk order (default is LSB-first).
module fifo_rd_unpack #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_ena,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = $clog2(RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                xfer;
    logic                last;
    logic [IN_WIDTH-1:0] hold_shifted;

    assign xfer = hold_valid_q & out_ready;
    assign last = (cnt_q == CNT_LAST);

    // The pop reloads in the same cycle the final chunk leaves, so words run back to back.
    assign fifo_rd_ena = ~rst & ~fifo_empty & (~hold_valid_q | (xfer & last));

`ifdef FIFO_RD_UNPACK_MSB_FIRST_EN
    assign hold_shifted = hold_q << OUT_WIDTH;
    assign out_data     = hold_q[IN_WIDTH-1 -: OUT_WIDTH];
`else
    assign hold_shifted = hold_q >> OUT_WIDTH;
    assign out_data     = hold_q[OUT_WIDTH-1:0];
`endif

    assign out_valid = hold_valid_q;
    assign out_last  = hold_valid_q & last;

    always_comb begin
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        hold_valid_d = hold_valid_q;
        if (fifo_rd_ena) begin
            hold_d       = fifo_data;
            cnt_d        = '0;
            hold_valid_d = 1'b1;
        end else if (xfer && !last) begin
            hold_d = hold_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
        end else if (xfer && last) begin
            hold_valid_d = 1'b0;
        end
    end

    // Reset discards any partial word; the data register itself needs no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: doc/fifo_rd_unpack.md
# fifo_rd_unpack

Read-side companion for the team's synchronous show-ahead FIFOs. It drains IN_WIDTH-bit words from a FIFO read port (`rd_data`/`rd_ena`/`rd_empty` semantics) and emits each word as RATIO consecutive OUT_WIDTH-bit chunks on a valid/ready stream. It sits between a wide FIFO and a narrow consumer such as a serializer or bus-width adapter, and sustains one chunk per cycle with no bubbles between words.

## Interface
Parameters:
- `IN_WIDTH`, 16, FIFO word width; must be an integer multiple of `OUT_WIDTH`.
- `OUT_WIDTH`, 4, output chunk width.
- RATIO (derived) = `IN_WIDTH/OUT_WIDTH`; must be ≥ 2. Counter width is `$clog2(RATIO)`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fifo_data` in IN_WIDTH: FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_ena` out 1: pops the head word; combinational and never asserted while `fifo_empty`=1.
- `out_data` out OUT_WIDTH: current chunk.
- `out_valid` out 1: chunk valid.
- `out_ready` in 1: consumer accepts the chunk when `out_valid` and `out_ready` are both 1.
- `out_last` out 1: current chunk is the final chunk of its word.

## Operation
- State:
  - hold register `hold` (IN_WIDTH bits, not reset).
  - `hold_valid` (reset 0).
  - chunk counter `cnt` (reset 0).
- Define `xfer = out_valid & out_ready` and `last = (cnt == RATIO-1)`.
- `fifo_rd_ena = ~rst & ~fifo_empty & (~hold_valid | (xfer & last))`.
- Load: when `fifo_rd_ena`=1, at the next edge `hold <= fifo_data`, `cnt <= 0`, `hold_valid <= 1`.
- Advance: when `xfer & ~last`, `cnt <= cnt+1` and `hold` shifts by OUT_WIDTH toward the emitted end.
- Drain: when `xfer & last` and no load, `hold_valid <= 0`.
- Outputs:
  - `out_valid = hold_valid`.
  - `out_last = hold_valid & last`.
  - `out_data` is the emitted-end slice of `hold`. The default order is LSB-first: chunk k = `word[k*OUT_WIDTH +: OUT_WIDTH]`.
- Backpressure: when `out_ready`=0, `hold`, `cnt` and `out_data` hold. No pop occurs while `hold_valid`=1 and the last chunk has not been accepted.
- Simultaneous last-chunk accept and non-empty FIFO: the pop and reload happen in the same cycle, so chunk 0 of the next word follows on the next cycle.
- Reset mid-word: the partial word is discarded, the counter returns to 0, and the FIFO is not popped during `rst`. The next word starts at chunk 0.
- Reset values:
  - `out_valid`=0, `out_last`=0, `fifo_rd_ena`=0.
  - `out_data` is undefined until the first load and must be ignored while `out_valid`=0.

## Timing
- Latency: FIFO word present (`fifo_empty`=0) with the unit idle in cycle N → pop in cycle N → chunk 0 valid in cycle N+1.
- Throughput: one chunk per cycle with `out_ready` held at 1. A word occupies exactly RATIO cycles. There are no idle cycles between words while the FIFO is non-empty.
- `fifo_rd_ena` depends combinationally on `out_ready`. The FIFO read port must tolerate this path, which the team's FIFOs do.
- After the last chunk is accepted with the FIFO empty, `out_valid` falls in the next cycle.

## Configuration
- `FIFO_RD_UNPACK_MSB_FIRST_EN`
  - Defined: chunks are emitted MSB-first; chunk k = `word[IN_WIDTH-(k+1)*OUT_WIDTH +: OUT_WIDTH]`. `hold` shifts toward the MSB end.
  - Undefined (default): chunks are emitted LSB-first as described above.
  - The handshake, latency and `out_last` behaviour are identical in both modes.

## Test plan
All scenarios use IN_WIDTH=16 and OUT_WIDTH=4.
- Reset: hold `rst`=1 for 2 cycles with `fifo_empty`=0 → `fifo_rd_ena`=0 and `out_valid`=0 throughout. The first pop occurs in the cycle after `rst` falls.
- Single word 0xABCD, `out_ready`=1:
  - `out_data` is 0xD, 0xC, 0xB, 0xA on 4 consecutive cycles.
  - `out_last`=1 only on 0xA.
  - Exactly one `fifo_rd_ena` pulse.
  - With `FIFO_RD_UNPACK_MSB_FIRST_EN` defined, the order is 0xA, 0xB, 0xC, 0xD.
- Back-to-back words 0x1234, 0x5678, `out_ready`=1:
  - 8 consecutive valid chunks: 4, 3, 2, 1, 8, 7, 6, 5.
  - The second pop occurs in the same cycle that chunk 0x1 is accepted.
- Backpressure: with word 0xABCD, drop `out_ready` for 3 cycles after 0xC is accepted → `out_data`=0xB stable, no pop. Then 0xB, 0xA complete the word normally.
- Underflow: FIFO empties after one word → `out_valid`=0 in the cycle after 0xA is accepted, `fifo_rd_ena` stays 0, and `out_valid` stays 0 until `fifo_empty` falls.
- Reset mid-word:
  - After 0xD and 0xC of 0xABCD, assert `rst` for 1 cycle.
  - With 0x1234 next at the FIFO head, the output restarts at 0x4.
  - No 0xB or 0xA is ever emitted.
